// File: rtl/fib_sequencer.sv
`default_nettype none
// ============================================================================
// fib_sequencer - request front-end, engine timer and result FIFO for the
// fibonacci engine. Define FIB_SEQ_OVF_EN to add the per-entry res_ovf flag.
// Revision: 1.0
// ============================================================================
module fib_sequencer #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 258
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_n,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_fn,
  output logic [7:0]  res_n,
`ifdef FIB_SEQ_OVF_EN
  output logic        res_ovf,
`endif
  output logic [7:0]  fib_n,
  output logic        fib_st,
  input  logic [31:0] fib_fn,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    FLUSH  = 2'd0,
    IDLE   = 2'd1,
    LAUNCH = 2'd2,
    WAIT   = 2'd3
  } state_t;

  state_t        state, state_d;
  logic [FW-1:0] flush_cnt;
  logic [7:0]    n_q;
  logic [8:0]    wait_cnt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          accept, push, pop;

  logic [31:0]   mem_fn [DEPTH];
  logic [7:0]    mem_n  [DEPTH];

  // Space is reserved at accept time, so the result push can never overflow.
  assign req_ready = (state == IDLE) && (count < FULL_COUNT);
  assign accept    = req_valid && req_ready;
  assign push      = (state == WAIT) && (wait_cnt == '0);
  assign res_valid = (count != '0);
  assign pop       = res_valid && res_ready;
  assign fib_n     = n_q;
  assign fib_st    = (state == LAUNCH);
  assign busy      = (state != IDLE);
  assign res_fn    = res_valid ? mem_fn[rd_ptr] : '0;
  assign res_n     = res_valid ? mem_n[rd_ptr]  : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FLUSH;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      FLUSH:   if (flush_cnt == FLUSH_LAST) state_d = IDLE;
      IDLE:    if (accept) state_d = LAUNCH;
      LAUNCH:  state_d = WAIT;
      WAIT:    if (push) state_d = IDLE;
      default: state_d = FLUSH;
    endcase
  end

  // The engine has no done flag: fn is valid n+1 edges after st is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= '0;
      n_q       <= '0;
      wait_cnt  <= '0;
    end else begin
      if (state == FLUSH) flush_cnt <= flush_cnt + FW'(1);
      if (accept)         n_q       <= req_n;
      if (state == LAUNCH)    wait_cnt <= {1'b0, n_q} + 9'd1;
      else if (state == WAIT) wait_cnt <= wait_cnt - 9'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_fn[wr_ptr] <= fib_fn;
      mem_n[wr_ptr]  <= n_q;
    end
  end

`ifdef FIB_SEQ_OVF_EN
  logic mem_ovf [DEPTH];

  always_ff @(posedge clk) begin
    if (push) mem_ovf[wr_ptr] <= (n_q > 8'd47);
  end

  assign res_ovf = res_valid && mem_ovf[rd_ptr];
`endif

endmodule
`default_nettype wire

// File: tb/tb_fib_sequencer.sv
`default_nettype none
// ============================================================================
// tb_fib_sequencer - vector table, directed corner cases and random traffic
// against a behavioural engine and an in-order result scoreboard.
// ============================================================================
module tb_fib_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_n;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_fn;
  logic [7:0]  res_n;
`ifdef FIB_SEQ_OVF_EN
  logic        res_ovf;
`endif
  logic [7:0]  fib_n;
  logic        fib_st;
  logic [31:0] fib_fn = '0;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fib_sequencer #(.DEPTH(4), .FLUSH_CYCLES(258)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_n     (req_n),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_fn    (res_fn),
    .res_n     (res_n),
`ifdef FIB_SEQ_OVF_EN
    .res_ovf   (res_ovf),
`endif
    .fib_n     (fib_n),
    .fib_st    (fib_st),
    .fib_fn    (fib_fn),
    .busy      (busy)
  );

  function automatic logic [31:0] fib_ref(input logic [7:0] n);
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd1;
    logic [31:0] t;
    for (int i = 0; i < int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic void check(input string name, input longint unsigned act,
                                input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Engine model: no reset, fn updates n+1 edges after the edge sampling st.
  int         eng_cnt = 0;
  logic [7:0] eng_n   = '0;
  always @(posedge clk) begin
    if (fib_st) check("engine_idle_at_st", eng_cnt, 0);
    if (eng_cnt > 0) begin
      if (eng_cnt == 1) fib_fn <= fib_ref(eng_n);
      eng_cnt <= eng_cnt - 1;
    end else if (fib_st) begin
      eng_n   <= fib_n;
      eng_cnt <= int'(fib_n) + 1;
    end
  end

  // In-order scoreboard of accepted requests.
  typedef struct {
    logic [7:0]  n;
    logic [31:0] fn;
  } exp_t;
  exp_t exp_q[$];

  always @(posedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (res_valid && res_ready) begin
        check("scoreboard_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("mon_res_n", res_n, e.n);
          check("mon_res_fn", res_fn, e.fn);
`ifdef FIB_SEQ_OVF_EN
          check("mon_res_ovf", res_ovf, e.n > 8'd47);
`endif
        end
      end
      if (req_valid && req_ready) begin
        e.n  = req_n;
        e.fn = fib_ref(req_n);
        exp_q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_flush();
    int k = 0;
    int st_seen = 0;
    while (!req_ready && k < 400) begin
      tick();
      k++;
      st_seen += int'(fib_st);
    end
    check("flush_ready_edge", k, 258);
    check("flush_st_low", st_seen, 0);
  endtask

  task automatic send_req(input logic [7:0] n);
    int k = 0;
    req_valid = 1'b1;
    req_n     = n;
    while (!req_ready && k < 600) begin
      tick();
      k++;
    end
    check("accept_within_budget", k < 600, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 600) begin
      tick();
      k++;
    end
    check("idle_within_budget", k < 600, 1);
  endtask

  typedef struct {
    logic [7:0]  n;
    logic [31:0] fn;
    logic        ovf;
  } vec_t;

  task automatic run_one(input vec_t v);
    int lat = 0;
    int st_cnt;
    res_ready = 1'b1;
    send_req(v.n);
    st_cnt = int'(fib_st);
    check("launch_fib_n", fib_n, v.n);
    while (!res_valid && lat < 600) begin
      tick();
      lat++;
      st_cnt += int'(fib_st);
    end
    check("latency", lat, int'(v.n) + 3);
    check("st_pulses", st_cnt, 1);
    check("res_fn", res_fn, v.fn);
    check("res_n", res_n, v.n);
`ifdef FIB_SEQ_OVF_EN
    check("res_ovf", res_ovf, v.ovf);
`endif
    tick();
    check("popped_empty", res_valid, 0);
  endtask

  vec_t        tbl[10];
  logic [31:0] drain_exp[4];

  initial begin
    tbl[0] = '{8'd10, 32'd55,         1'b0};
    tbl[1] = '{8'd0,  32'd0,          1'b0};
    tbl[2] = '{8'd1,  32'd1,          1'b0};
    tbl[3] = '{8'd2,  32'd1,          1'b0};
    tbl[4] = '{8'd3,  32'd2,          1'b0};
    tbl[5] = '{8'd6,  32'd8,          1'b0};
    tbl[6] = '{8'd20, 32'd6765,       1'b0};
    tbl[7] = '{8'd30, 32'd832040,     1'b0};
    tbl[8] = '{8'd47, 32'd2971215073, 1'b0};
    tbl[9] = '{8'd48, 32'd512559680,  1'b1};
    drain_exp[0] = 32'd1;
    drain_exp[1] = 32'd1;
    drain_exp[2] = 32'd2;
    drain_exp[3] = 32'd3;

    // Reset values, then flush with a request already pending.
    rst_n = 1'b0; req_valid = 1'b1; req_n = 8'd10; res_ready = 1'b1;
    tick(); tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_fn", res_fn, 0);
    check("rst_res_n", res_n, 0);
    check("rst_fib_n", fib_n, 0);
    check("rst_fib_st", fib_st, 0);
    check("rst_busy", busy, 1);
`ifdef FIB_SEQ_OVF_EN
    check("rst_res_ovf", res_ovf, 0);
`endif
    rst_n = 1'b1;
    wait_flush();

    foreach (tbl[i]) run_one(tbl[i]);

    // Fill the FIFO, then check back-pressure and drain order.
    res_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_req(8'(i));
    wait_idle();
    check("full_ready_low", req_ready, 0);
    check("full_valid", res_valid, 1);
    check("drain_0", res_fn, drain_exp[0]);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    check("ready_after_pop", req_ready, 1);
    for (int i = 1; i < 4; i++) begin
      check("drain_order", res_fn, drain_exp[i]);
      res_ready = 1'b1; tick(); res_ready = 1'b0;
    end
    check("drain_empty", res_valid, 0);

    // Pop on the same edge as a WAIT completion with two entries held.
    send_req(8'd3);
    send_req(8'd4);
    wait_idle();
    send_req(8'd6);
    repeat (8) tick();
    check("pp_head_before", res_fn, 2);
    check("pp_busy_before", busy, 1);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    check("pp_valid", res_valid, 1);
    check("pp_head_after", res_fn, 3);
    check("pp_idle_after", busy, 0);
    res_ready = 1'b1; tick();
    check("pp_tail_fn", res_fn, 8);
    check("pp_tail_n", res_n, 6);
    tick(); res_ready = 1'b0;
    check("pp_empty", res_valid, 0);

    // Asynchronous reset in the middle of a long computation.
    send_req(8'd5);
    wait_idle();
    check("pre_rst_valid", res_valid, 1);
    send_req(8'd200);
    repeat (50) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_res_valid", res_valid, 0);
    check("midrst_req_ready", req_ready, 0);
    check("midrst_busy", busy, 1);
    check("midrst_fib_st", fib_st, 0);
    check("midrst_fib_n", fib_n, 0);
    check("midrst_res_fn", res_fn, 0);
    check("midrst_res_n", res_n, 0);
    tick();
    rst_n = 1'b1;
    wait_flush();
    run_one('{8'd5, 32'd5, 1'b0});

    // Random traffic checked by the scoreboard.
    for (int c = 0; c < 1500; c++) begin
      req_valid = ($urandom_range(0, 1) == 1);
      req_n     = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(48, 120))
                                              : 8'($urandom_range(0, 47));
      res_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = 1'b0;
    res_ready = 1'b1;
    begin
      int k = 0;
      while ((exp_q.size() != 0 || busy) && k < 600) begin
        tick();
        k++;
      end
    end
    check("random_drained", exp_q.size(), 0);
    check("random_valid_clear", res_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fib_sequencer.md
# fib_sequencer

Request front-end and result buffer for the `fibonacci` engine. Accepts `n` requests over a valid/ready handshake and drives the engine's `n`/`st` inputs with correct timing. Because the engine has no done flag, the block times each computation from `n`, captures `fn`, and queues tagged results in an output FIFO. It also flushes the engine after reset, since the engine itself has no reset.

## Interface
- `DEPTH`, 4: result FIFO depth, power of 2, ≥2.
- `FLUSH_CYCLES`, 258: idle cycles with `fib_st`=0 after reset; guarantees the engine has returned to `inicio` from any state and `c` value.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on an edge where `req_valid` & `req_ready`.
- `req_n` in 8: Fibonacci index.
- `res_valid` out 1: FIFO head valid.
- `res_ready` in 1: consumer pops the head on an edge where `res_valid` & `res_ready`.
- `res_fn` out 32: F(n) mod 2^32.
- `res_n` out 8: index tag of the head entry.
- `fib_n` out 8: to engine `n`.
- `fib_st` out 1: to engine `st`.
- `fib_fn` in 32: from engine `fn`.
- `busy` out 1: state ≠ IDLE.

## Operation
- FSM states: FLUSH, IDLE, LAUNCH, WAIT.
- FLUSH: entered on reset. Counts `FLUSH_CYCLES` cycles, then goes to IDLE.
- IDLE: `req_ready` = (FIFO count < `DEPTH`). `req_ready` is a function of registered count only; there is no combinational path from `res_ready`. On handshake, latch `req_n` into `n_q` and go to LAUNCH.
- LAUNCH: `fib_st`=1 for exactly this one cycle. Load `wait_cnt`=`n_q`+1 and go to WAIT.
- WAIT: decrement `wait_cnt` each cycle. In the cycle where `wait_cnt`=0, push {`n_q`, `fib_fn`} into the FIFO and return to IDLE.
- `fib_n` = `n_q` at all times. It is held stable from LAUNCH until the next accept.
- Engine contract: `fn` updates n+1 edges after the edge that samples `st`, and the engine is back in `inicio` on that same edge.
- FIFO is show-ahead: `res_fn`/`res_n` present the head entry whenever `res_valid`=1.
- A FIFO push and pop on the same edge is legal; count is unchanged.
- A push can never hit a full FIFO, because `req_ready` requires free space before a request is accepted.
- The FIFO count includes no in-flight slot; the launch gate guarantees space for the result.
- Results leave the FIFO in request order.
- Arithmetic: `fib_fn` wraps mod 2^32 for n ≥ 48. There is no saturation.

## Timing
- Reset values: `req_ready`=0, `res_valid`=0, `res_fn`=0, `res_n`=0, `fib_n`=0, `fib_st`=0, `busy`=1. FIFO is empty, state is FLUSH.
- After reset, `req_ready` rises on the `FLUSH_CYCLES`-th edge after `rst_n` deasserts.
- Latency: request accepted at edge A → `res_valid`=1 after edge A+n+3 (FIFO previously empty).
- Throughput: next accept is possible at edge A+n+4 at the earliest.
- Reset mid-operation (any state): all outputs return to reset values immediately and the FIFO contents are discarded. The block re-enters FLUSH, which covers an engine left mid-`calculo`.

## Configuration
- `FIB_SEQ_OVF_EN` defined:
  - Adds output `res_ovf` (1 bit), stored per FIFO entry, = (n > 47), meaning `res_fn` has wrapped.
  - `res_ovf` reset value is 0.
- `FIB_SEQ_OVF_EN` undefined: `res_ovf` port and storage are absent. Behaviour is otherwise identical.

## Test plan
- Reset, then hold `req_valid`=1 → `req_ready`=0 and `fib_st`=0 for 258 cycles, then `req_ready`=1.
- `req_n`=10 with `res_ready`=1 → `res_valid` 13 cycles after accept, `res_fn`=55, `res_n`=10, `fib_st` high for exactly 1 cycle.
- Index sweep with `FIB_SEQ_OVF_EN`:
  - `req_n`=0 → 0, `res_ovf`=0.
  - `req_n`=1 → 1, `res_ovf`=0.
  - `req_n`=47 → 2971215073, `res_ovf`=0.
  - `req_n`=48 → 512559680, `res_ovf`=1.
- `res_ready`=0, send n=1,2,3,4 (`DEPTH`=4) → `req_ready` drops after the 4th push. Pop one → `req_ready`=1 next cycle. Drain order: 1,1,2,3.
- FIFO holding 2 entries; assert `res_ready`=1 in the same cycle a WAIT completes with n=6 → count stays 2, and the entry `res_fn`=8 appears at the tail.
- Assert `rst_n`=0 during WAIT for n=200 → outputs reset asynchronously and the FIFO is empty. After the 258-cycle flush, `req_n`=5 → `res_fn`=5.
